// File: rtl/csr_trap_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_if : pipeline / CSR-file side signals of the trap sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface csr_trap_ctrl_if;
  logic [31:0] pc_i;
  logic        exc_i;
  logic [3:0]  exc_cause_i;
  logic        mret_i;
  logic        irq_ext_i;
  logic        irq_tmr_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  // Pipeline / CSR file side: drives events and CSR read values.
  modport master (
    output pc_i, exc_i, exc_cause_i, mret_i, irq_ext_i, irq_tmr_i,
           mstatus_i, mie_i, mepc_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_pc_o
  );

  // Trap sequencer side.
  modport slave (
    input  pc_i, exc_i, exc_cause_i, mret_i, irq_ext_i, irq_tmr_i,
           mstatus_i, mie_i, mepc_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_pc_o
  );
endinterface

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl : machine-mode trap entry / mret sequencer driving the CSR
//                 write port and a one-cycle PC redirect.
// Optional: `define CSR_TRAP_VECTORED_EN for vectored interrupt targets.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  csr_trap_ctrl_if.slave    bus
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STAT_T = 3'd3,
    W_STAT_R = 3'd4,
    REDIR    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] stat_q, stat_d;
  logic        ret_q, ret_d;
  logic        irq_block_q;

  logic        irq_ext_en;
  logic        irq_tmr_en;
  logic        irq_take;
  logic        accept;
  logic [31:0] base_pc;
  logic [31:0] trap_pc;

  assign irq_ext_en = bus.irq_ext_i & bus.mie_i[11];
  assign irq_tmr_en = bus.irq_tmr_i & bus.mie_i[7];
  assign irq_take   = bus.mstatus_i[3] & (irq_ext_en | irq_tmr_en) & ~irq_block_q;
  // Gated by rst so every output reads 0 while reset is held.
  assign accept     = rst & (state_q == IDLE) & (bus.exc_i | bus.mret_i | irq_take);
  assign base_pc    = {MTVEC_BASE[31:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  assign trap_pc = cause_q[31] ? (base_pc + {26'd0, cause_q[3:0], 2'b00}) : base_pc;
`else
  assign trap_pc = base_pc;
`endif

  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    cause_d           = cause_q;
    mepc_d            = mepc_q;
    stat_d            = stat_q;
    ret_d             = ret_q;
    bus.csr_we_o      = 1'b0;
    bus.csr_waddr_o   = 12'h000;
    bus.csr_wdata_o   = 32'h0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = 32'h0;
    bus.stall_o       = (state_q != IDLE) | accept;

    case (state_q)
      IDLE: begin
        if (accept) begin
          epc_d  = bus.pc_i;
          mepc_d = bus.mepc_i;
          stat_d = bus.mstatus_i;
          if (bus.exc_i) begin
            cause_d = {28'd0, bus.exc_cause_i};
            ret_d   = 1'b0;
            state_d = W_EPC;
          end else if (bus.mret_i) begin
            ret_d   = 1'b1;
            state_d = W_STAT_R;
          end else begin
            cause_d = irq_ext_en ? 32'h8000_000B : 32'h8000_0007;
            ret_d   = 1'b0;
            state_d = W_EPC;
          end
        end
      end
      W_EPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MEPC;
        bus.csr_wdata_o = {epc_q[31:2], 2'b00};
        state_d         = W_CAUSE;
      end
      W_CAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MCAUSE;
        bus.csr_wdata_o = cause_q;
        state_d         = W_STAT_T;
      end
      W_STAT_T: begin
        // MPIE <- MIE, MIE <- 0, MPP <- M
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MSTATUS;
        bus.csr_wdata_o = {stat_q[31:13], 2'b11, stat_q[10:8], stat_q[3], stat_q[6:4], 1'b0, stat_q[2:0]};
        state_d         = REDIR;
      end
      W_STAT_R: begin
        // MIE <- MPIE, MPIE <- 1, MPP <- M
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MSTATUS;
        bus.csr_wdata_o = {stat_q[31:13], 2'b11, stat_q[10:8], 1'b1, stat_q[6:4], stat_q[7], stat_q[2:0]};
        state_d         = REDIR;
      end
      REDIR: begin
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = ret_q ? mepc_q : trap_pc;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      epc_q       <= 32'h0;
      cause_q     <= 32'h0;
      mepc_q      <= 32'h0;
      stat_q      <= 32'h0;
      ret_q       <= 1'b0;
      irq_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      mepc_q      <= mepc_d;
      stat_q      <= stat_d;
      ret_q       <= ret_d;
      // Masks interrupts for the single IDLE cycle that follows a redirect.
      irq_block_q <= (state_q == REDIR);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl : directed stimulus with a cycle-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_csr_trap_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk;
  logic rst;
  csr_trap_ctrl_if bus ();

  csr_trap_ctrl #(.MTVEC_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
  } step_t;

  step_t       exp_q[$];
  logic        blk = 1'b0;
  logic [43:0] wlog[$];
  logic [31:0] rlog[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] trap_target(input logic [31:0] cause);
`ifdef CSR_TRAP_VECTORED_EN
    if (cause[31]) return BASE + 4 * (cause & 32'hF);
`endif
    return BASE;
  endfunction

  // Reference model + per-cycle compare, on the falling edge.
  always @(negedge clk) begin
    step_t       e;
    logic        exp_stall;
    logic        blk_next;
    logic        ext_en, tmr_en, take_irq, acc;
    logic [31:0] cause, s, st;
    logic [78:0] act_v, exp_v;
    e         = '0;
    exp_stall = 1'b0;
    blk_next  = 1'b0;
    if (!rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      exp_stall = 1'b1;
      blk_next  = e.redir;
    end else begin
      ext_en   = bus.irq_ext_i && bus.mie_i[11];
      tmr_en   = bus.irq_tmr_i && bus.mie_i[7];
      take_irq = bus.mstatus_i[3] && (ext_en || tmr_en) && !blk;
      acc      = bus.exc_i || bus.mret_i || take_irq;
      exp_stall = acc;
      s = bus.mstatus_i;
      if (bus.exc_i || (!bus.mret_i && take_irq)) begin
        cause = bus.exc_i ? 32'(bus.exc_cause_i) : (ext_en ? 32'h8000_000B : 32'h8000_0007);
        st    = (s & ~32'h0000_1888) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
        exp_q.push_back('{1'b1, 12'h341, bus.pc_i & ~32'h3, 1'b0, 32'h0});
        exp_q.push_back('{1'b1, 12'h342, cause, 1'b0, 32'h0});
        exp_q.push_back('{1'b1, 12'h300, st, 1'b0, 32'h0});
        exp_q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, trap_target(cause)});
      end else if (bus.mret_i) begin
        st = (s & ~32'h0000_1888) | (((s >> 7) & 32'h1) << 3) | 32'h1880;
        exp_q.push_back('{1'b1, 12'h300, st, 1'b0, 32'h0});
        exp_q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, bus.mepc_i});
      end
    end
    act_v = {bus.stall_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o,
             bus.redirect_o, bus.redirect_o ? bus.redirect_pc_o : 32'h0};
    exp_v = {exp_stall, e.we, e.addr, e.data, e.redir, e.rpc};
    chk("cycle_outputs", 96'(act_v), 96'(exp_v));
    if (rst && bus.csr_we_o) wlog.push_back({bus.csr_waddr_o, bus.csr_wdata_o});
    if (rst && bus.redirect_o) rlog.push_back(bus.redirect_pc_o);
    blk = blk_next;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    bus.pc_i = 32'h0; bus.exc_i = 1'b0; bus.exc_cause_i = 4'h0; bus.mret_i = 1'b0;
    bus.irq_ext_i = 1'b0; bus.irq_tmr_i = 1'b0;
    bus.mstatus_i = 32'h0; bus.mie_i = 32'h0; bus.mepc_i = 32'h0;
  endtask

  task automatic clear_logs;
    wlog.delete();
    rlog.delete();
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // Exception: pc 0x40, cause 2, mstatus 0x8
    clear_logs();
    bus.pc_i = 32'h40; bus.exc_i = 1'b1; bus.exc_cause_i = 4'd2; bus.mstatus_i = 32'h8;
    cyc(1);
    clear_in();
    cyc(6);
    chk("exc_nwrites", 96'(wlog.size()), 96'd3);
    if (wlog.size() == 3) begin
      chk("exc_mepc",    96'(wlog[0]), 96'({12'h341, 32'h40}));
      chk("exc_mcause",  96'(wlog[1]), 96'({12'h342, 32'h2}));
      chk("exc_mstatus", 96'(wlog[2]), 96'({12'h300, 32'h1880}));
    end
    chk("exc_nredir", 96'(rlog.size()), 96'd1);
    if (rlog.size() == 1) chk("exc_target", 96'(rlog[0]), 96'h100);

    // Mret: mstatus 0x1880, mepc 0x44
    clear_logs();
    bus.mret_i = 1'b1; bus.mstatus_i = 32'h1880; bus.mepc_i = 32'h44; bus.pc_i = 32'h200;
    cyc(1);
    clear_in();
    cyc(4);
    chk("mret_nwrites", 96'(wlog.size()), 96'd1);
    if (wlog.size() == 1) chk("mret_mstatus", 96'(wlog[0]), 96'({12'h300, 32'h1888}));
    chk("mret_nredir", 96'(rlog.size()), 96'd1);
    if (rlog.size() == 1) chk("mret_target", 96'(rlog[0]), 96'h44);

    // Timer pending but MIE=0: nothing happens
    clear_logs();
    bus.irq_tmr_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_i = 32'h0; bus.pc_i = 32'h300;
    cyc(4);
    chk("irq_gated", 96'(wlog.size()), 96'd0);
    // MIE=1: timer trap taken
    bus.mstatus_i = 32'h8;
    cyc(1);
    clear_in();
    cyc(6);
    chk("tmr_nwrites", 96'(wlog.size()), 96'd3);
    if (wlog.size() == 3) chk("tmr_mcause", 96'(wlog[1]), 96'({12'h342, 32'h8000_0007}));
    chk("tmr_nredir", 96'(rlog.size()), 96'd1);
`ifdef CSR_TRAP_VECTORED_EN
    if (rlog.size() == 1) chk("tmr_target", 96'(rlog[0]), 96'h11C);
`else
    if (rlog.size() == 1) chk("tmr_target", 96'(rlog[0]), 96'h100);
`endif

    // External + timer held through the post-redirect cycle: one trap only
    clear_logs();
    bus.irq_ext_i = 1'b1; bus.irq_tmr_i = 1'b1; bus.mie_i = 32'h880;
    bus.mstatus_i = 32'h8; bus.pc_i = 32'h304;
    cyc(6);
    clear_in();
    cyc(3);
    chk("ext_nwrites", 96'(wlog.size()), 96'd3);
    if (wlog.size() == 3) chk("ext_mcause", 96'(wlog[1]), 96'({12'h342, 32'h8000_000B}));

    // Priority: exception, mret and enabled interrupt together
    clear_logs();
    bus.exc_i = 1'b1; bus.exc_cause_i = 4'd5; bus.mret_i = 1'b1;
    bus.irq_tmr_i = 1'b1; bus.mie_i = 32'h80; bus.mstatus_i = 32'h8;
    bus.pc_i = 32'h82; bus.mepc_i = 32'h500;
    cyc(1);
    clear_in();
    cyc(6);
    chk("prio_nwrites", 96'(wlog.size()), 96'd3);
    if (wlog.size() == 3) begin
      chk("prio_mepc",    96'(wlog[0]), 96'({12'h341, 32'h80}));
      chk("prio_mcause",  96'(wlog[1]), 96'({12'h342, 32'h5}));
      chk("prio_mstatus", 96'(wlog[2]), 96'({12'h300, 32'h1880}));
    end
    if (rlog.size() == 1) chk("prio_target", 96'(rlog[0]), 96'h100);

    // Reset asserted at N+2 aborts the trap
    clear_logs();
    bus.pc_i = 32'h60; bus.exc_i = 1'b1; bus.exc_cause_i = 4'd3; bus.mstatus_i = 32'h8;
    cyc(1);
    clear_in();
    cyc(1);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(4);
    chk("rst_nwrites", 96'(wlog.size()), 96'd1);
    chk("rst_nredir",  96'(rlog.size()), 96'd0);
    chk("rst_idle", 96'({bus.stall_o, bus.csr_we_o, bus.redirect_o, bus.csr_waddr_o}), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
